data_cache_dm: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and data_memory.
//  CPU side: byte-wide, BUSYWAIT-stalled interface. Memory side: 32-bit block transfers with MEM_BUSYWAIT handshake.

---
 rtl/data_cache_dm_pkg.sv | 33 +++
 rtl/data_cache_dm_line_store.sv | 73 +++++++
 rtl/data_cache_dm.sv | 165 ++++++++++++++++
 tb/tb_data_cache_dm.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_dm_pkg.sv
// Shared definitions for the direct-mapped data cache.
//   - default geometry (8 lines x 4 bytes, 8-bit byte address)
//   - controller state encoding (2 bits)
//   - line-store write command encoding
package data_cache_dm_pkg;

    localparam int unsigned DEF_NUM_BLOCKS  = 8;
    localparam int unsigned DEF_BLOCK_BYTES = 4;
    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned BYTE_W          = 8;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWriteback = 2'd1,
        StFetch     = 2'd2,
        StUpdate    = 2'd3
    } dcache_state_e;

    // One write port into the line store; only one of these can happen per cycle.
    typedef enum logic [1:0] {
        WrNone  = 2'd0,  // no update
        WrByte  = 2'd1,  // store hit: one byte, marks line dirty
        WrFill  = 2'd2,  // refill: whole line + tag, valid=1, dirty=0
        WrClean = 2'd3   // write-back accepted: dirty=0
    } line_wr_e;

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned num_blocks,
                                              input int unsigned block_bytes);
        return addr_w - $clog2(num_blocks) - $clog2(block_bytes);
    endfunction

endpackage

// File: rtl/data_cache_dm_line_store.sv
// Valid/dirty/tag/data arrays for the direct-mapped data cache.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears valid/dirty only)
//   idx         line selected for both the read and the write port
//   cmd         write command (none / byte / fill / clean)
//   offset      byte position within the line for WrByte
//   wr_byte     byte written by WrByte
//   wr_tag      tag stored by WrFill
//   wr_line     line stored by WrFill
//   valid, dirty, tag, line   combinational read of line idx
module data_cache_dm_line_store
    import data_cache_dm_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS  = DEF_NUM_BLOCKS,
    parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int unsigned TAG_W       = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [$clog2(NUM_BLOCKS)-1:0]      idx,
    input  line_wr_e                           cmd,
    input  logic [$clog2(BLOCK_BYTES)-1:0]     offset,
    input  logic [BYTE_W-1:0]                  wr_byte,
    input  logic [TAG_W-1:0]                   wr_tag,
    input  logic [BYTE_W*BLOCK_BYTES-1:0]      wr_line,
    output logic                               valid,
    output logic                               dirty,
    output logic [TAG_W-1:0]                   tag,
    output logic [BYTE_W*BLOCK_BYTES-1:0]      line
);

    logic [NUM_BLOCKS-1:0]             valid_q;
    logic [NUM_BLOCKS-1:0]             dirty_q;
    logic [TAG_W-1:0]                  tag_q  [NUM_BLOCKS];
    logic [BYTE_W*BLOCK_BYTES-1:0]     data_q [NUM_BLOCKS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (cmd)
                WrByte:  dirty_q[idx] <= 1'b1;
                WrFill: begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                end
                WrClean: dirty_q[idx] <= 1'b0;
                default: ;
            endcase
        end
    end

    // Tag and data contents survive reset; only the valid bits make them meaningful.
    always_ff @(posedge clk) begin
        case (cmd)
            WrByte: data_q[idx][BYTE_W*offset +: BYTE_W] <= wr_byte;
            WrFill: begin
                data_q[idx] <= wr_line;
                tag_q[idx]  <= wr_tag;
            end
            default: ;
        endcase
    end

    always_comb begin
        valid = valid_q[idx];
        dirty = dirty_q[idx];
        tag   = tag_q[idx];
        line  = data_q[idx];
    end

endmodule

// File: rtl/data_cache_dm.sv
// Direct-mapped, write-back, write-allocate data cache.
// Ports:
//   CLK, RESET        clock, async active-low reset
//   READ, WRITE       CPU load/store requests (level, held until BUSYWAIT low)
//   ADDRESS           CPU byte address {tag, index, offset}
//   WRITEDATA         store byte
//   READDATA          load byte, valid when READ=1 and BUSYWAIT=0
//   BUSYWAIT          CPU stall
//   MEM_READ          block fetch request
//   MEM_WRITE         block write-back request
//   MEM_ADDRESS       block address {tag, index}
//   MEM_WRITEDATA     block being written back
//   MEM_READDATA      fetched block, valid when MEM_BUSYWAIT falls
//   MEM_BUSYWAIT      memory busy; a request completes on the first posedge it is low
module data_cache_dm
    import data_cache_dm_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS  = DEF_NUM_BLOCKS,
    parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  READ,
    input  logic                                  WRITE,
    input  logic [ADDR_W-1:0]                     ADDRESS,
    input  logic [BYTE_W-1:0]                     WRITEDATA,
    output logic [BYTE_W-1:0]                     READDATA,
    output logic                                  BUSYWAIT,
    output logic                                  MEM_READ,
    output logic                                  MEM_WRITE,
    output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0] MEM_ADDRESS,
    output logic [BYTE_W*BLOCK_BYTES-1:0]         MEM_WRITEDATA,
    input  logic [BYTE_W*BLOCK_BYTES-1:0]         MEM_READDATA,
    input  logic                                  MEM_BUSYWAIT
);

    localparam int unsigned OFFSET_W   = $clog2(BLOCK_BYTES);
    localparam int unsigned INDEX_W    = $clog2(NUM_BLOCKS);
    localparam int unsigned TAG_W      = tag_width(ADDR_W, NUM_BLOCKS, BLOCK_BYTES);
    localparam int unsigned BLK_ADDR_W = ADDR_W - OFFSET_W;
    localparam int unsigned LINE_W     = BYTE_W * BLOCK_BYTES;

    dcache_state_e           state_q, state_d;
    logic [BLK_ADDR_W-1:0]   miss_blk_q;  // {tag, index} of the miss being serviced
    logic [LINE_W-1:0]       fill_q;
    logic                    miss_start;
    logic                    fill_capture;

    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_W-1:0]      req_idx;
    logic [OFFSET_W-1:0]     req_off;
    logic [TAG_W-1:0]        miss_tag;
    logic [INDEX_W-1:0]      miss_idx;
    logic [INDEX_W-1:0]      line_idx;

    logic                    line_valid;
    logic                    line_dirty;
    logic [TAG_W-1:0]        line_tag;
    logic [LINE_W-1:0]       line_data;
    line_wr_e                wr_cmd;

    logic                    req;
    logic                    hit;

    assign req_tag  = ADDRESS[ADDR_W-1 -: TAG_W];
    assign req_idx  = ADDRESS[OFFSET_W +: INDEX_W];
    assign req_off  = ADDRESS[OFFSET_W-1:0];
    assign miss_tag = miss_blk_q[BLK_ADDR_W-1 -: TAG_W];
    assign miss_idx = miss_blk_q[INDEX_W-1:0];

    // Outside IDLE the line under service is addressed from the latched miss, so a CPU
    // that drops or changes its request cannot disturb an in-flight transfer.
    assign line_idx = (state_q == StIdle) ? req_idx : miss_idx;

    assign req = READ | WRITE;
    assign hit = line_valid && (line_tag == req_tag);

    data_cache_dm_line_store #(
        .NUM_BLOCKS  (NUM_BLOCKS),
        .BLOCK_BYTES (BLOCK_BYTES),
        .TAG_W       (TAG_W)
    ) u_line_store (
        .clk     (CLK),
        .rst_n   (RESET),
        .idx     (line_idx),
        .cmd     (wr_cmd),
        .offset  (req_off),
        .wr_byte (WRITEDATA),
        .wr_tag  (miss_tag),
        .wr_line (fill_q),
        .valid   (line_valid),
        .dirty   (line_dirty),
        .tag     (line_tag),
        .line    (line_data)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            miss_blk_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                miss_blk_q <= ADDRESS[ADDR_W-1:OFFSET_W];
            end
            if (fill_capture) begin
                fill_q <= MEM_READDATA;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        BUSYWAIT      = 1'b0;
        READDATA      = '0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = miss_blk_q;
        MEM_WRITEDATA = line_data;
        wr_cmd        = WrNone;
        miss_start    = 1'b0;
        fill_capture  = 1'b0;

        case (state_q)
            StIdle: begin
                if (req && !hit) begin
                    BUSYWAIT   = 1'b1;
                    miss_start = 1'b1;
                    state_d    = (line_valid && line_dirty) ? StWriteback : StFetch;
                end else if (WRITE) begin
                    // READ and WRITE together behave as a store
                    wr_cmd = WrByte;
                end else if (READ) begin
                    READDATA = line_data[BYTE_W*req_off +: BYTE_W];
                end
            end
            StWriteback: begin
                BUSYWAIT    = 1'b1;
                MEM_WRITE   = 1'b1;
                MEM_ADDRESS = {line_tag, miss_idx};
                if (!MEM_BUSYWAIT) begin
                    wr_cmd  = WrClean;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    fill_capture = 1'b1;
                    state_d      = StUpdate;
                end
            end
            StUpdate: begin
                BUSYWAIT = 1'b1;
                wr_cmd   = WrFill;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_data_cache_dm.sv
// Bench for data_cache_dm: memory responder (busy 5 cycles per request), a
// line-level reference model of the cache contents, and one compare process.
module tb_data_cache_dm;

    localparam int MEM_BUSY = 5;
    localparam int XFER     = MEM_BUSY + 1;  // busy cycles plus the completing cycle

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    data_cache_dm dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- memory responder ----------------
    logic [31:0] mem [64];
    bit          m_active;
    int          m_cnt;
    bit          m_write;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata;

    initial begin
        for (int b = 0; b < 64; b++) begin
            for (int k = 0; k < 4; k++) begin
                mem[b][8*k +: 8] = 8'((b * 4 + k) ^ 8'h5A);
            end
        end
        m_active     = 0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                m_active     = 0;
                MEM_BUSYWAIT = 1'b0;
            end else begin
                // busy dropped last negedge, so the posedge in between consumed it
                if (m_active && !MEM_BUSYWAIT) m_active = 0;
                if (m_active) begin
                    if (m_cnt == 0) begin
                        MEM_BUSYWAIT = 1'b0;
                        if (m_write) mem[m_addr] = m_wdata;
                        else         MEM_READDATA = mem[m_addr];
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end else if (MEM_READ || MEM_WRITE) begin
                    m_active     = 1;
                    MEM_BUSYWAIT = 1'b1;
                    m_cnt        = MEM_BUSY - 1;
                    m_write      = MEM_WRITE;
                    m_addr       = MEM_ADDRESS;
                    m_wdata      = MEM_WRITEDATA;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem  [64];
    bit          ref_valid[8];
    bit          ref_dirty[8];
    logic [2:0]  ref_tag  [8];
    logic [31:0] ref_data [8];

    // expectations for the access in flight
    bit          exp_wb_valid;
    logic [5:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic [5:0]  exp_fetch_addr;
    logic [7:0]  exp_rdata;
    int          exp_stall;
    bit          pin_rd_en;
    logic [7:0]  pin_rd_val;
    bit          pin_wb_en;
    logic [31:0] pin_wb_val;

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    int cur_stall;
    bit wb_seen;
    bit fetch_checked;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        cur_stall = 0;
        wb_seen = 0;
        fetch_checked = 0;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                check("reset_busywait", BUSYWAIT, 0);
                check("reset_mem_read", MEM_READ, 0);
                check("reset_mem_write", MEM_WRITE, 0);
                check("reset_readdata", READDATA, 0);
                cur_stall = 0;
                wb_seen = 0;
                fetch_checked = 0;
            end else begin
                check("mem_read_and_write", MEM_READ && MEM_WRITE, 0);
                if (MEM_WRITE) begin
                    wb_seen = 1;
                    check("mem_write_expected", MEM_WRITE, exp_wb_valid);
                    check("wb_address", MEM_ADDRESS, exp_wb_addr);
                    check("wb_data", MEM_WRITEDATA, exp_wb_data);
                    if (pin_wb_en) check("wb_data_literal", MEM_WRITEDATA, pin_wb_val);
                end
                if (MEM_READ) begin
                    check("fetch_address", MEM_ADDRESS, exp_fetch_addr);
                    if (!fetch_checked) check("writeback_before_fetch", wb_seen, exp_wb_valid);
                    fetch_checked = 1;
                end
                if (!READ && !WRITE) check("idle_readdata", READDATA, 0);
                if (READ || WRITE) begin
                    if (BUSYWAIT) begin
                        cur_stall++;
                    end else begin
                        check("stall_cycles", cur_stall, exp_stall);
                        if (READ && !WRITE) check("readdata", READDATA, exp_rdata);
                        if (pin_rd_en) check("readdata_literal", READDATA, pin_rd_val);
                        cur_stall = 0;
                        wb_seen = 0;
                        fetch_checked = 0;
                    end
                end else if (!BUSYWAIT) begin
                    cur_stall = 0;
                    wb_seen = 0;
                    fetch_checked = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wd);
        int         idx;
        int         off;
        logic [2:0] tg;
        bit         hit;
        idx = int'(addr[4:2]);
        off = int'(addr[1:0]);
        tg  = addr[7:5];
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        exp_wb_valid   = !hit && ref_valid[idx] && ref_dirty[idx];
        exp_wb_addr    = {ref_tag[idx], addr[4:2]};
        exp_wb_data    = ref_data[idx];
        exp_fetch_addr = addr[7:2];
        if (hit)               exp_stall = 0;
        else if (exp_wb_valid) exp_stall = 2 * XFER + 2;
        else                   exp_stall = XFER + 2;
        if (!hit) begin
            if (exp_wb_valid) ref_mem[exp_wb_addr] = ref_data[idx];
            ref_data[idx]  = ref_mem[addr[7:2]];
            ref_valid[idx] = 1;
            ref_dirty[idx] = 0;
            ref_tag[idx]   = tg;
        end
        exp_rdata = ref_data[idx][8*off +: 8];
        if (wr) begin
            ref_data[idx][8*off +: 8] = wd;
            ref_dirty[idx] = 1;
        end
        @(posedge CLK);
        #1;
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = addr;
        WRITEDATA = wd;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge CLK);
        while (BUSYWAIT) begin
            n++;
            if (n > 100) begin
                $display("FAIL wait_done: BUSYWAIT still high after %0d cycles, expected low", n);
                $fatal(1);
            end
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd, input bit pin_en, input logic [7:0] pin_val);
        pin_rd_en  = pin_en;
        pin_rd_val = pin_val;
        issue(rd, wr, addr, wd);
        wait_done();
        pin_rd_en = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        RESET = 1'b0;
        READ = 1'b0;
        WRITE = 1'b0;
        ADDRESS = '0;
        WRITEDATA = '0;
        pin_rd_en = 0;
        pin_wb_en = 0;
        exp_wb_valid = 0;
        exp_wb_addr = '0;
        exp_wb_data = '0;
        exp_fetch_addr = '0;
        exp_rdata = '0;
        exp_stall = 0;
        for (int b = 0; b < 64; b++) begin
            for (int k = 0; k < 4; k++) ref_mem[b][8*k +: 8] = 8'((b * 4 + k) ^ 8'h5A);
        end
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 0;
            ref_dirty[i] = 0;
            ref_tag[i]   = '0;
            ref_data[i]  = '0;
        end

        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;

        // clean miss, then hits on the same block
        access(1, 0, 8'h14, 8'h00, 1, 8'h4E);
        access(1, 0, 8'h15, 8'h00, 1, 8'h4F);
        access(0, 1, 8'h16, 8'hA5, 0, 8'h00);
        access(1, 0, 8'h16, 8'h00, 1, 8'hA5);

        // dirty miss on index 5, reset lands during the fetch
        pin_wb_en  = 1;
        pin_wb_val = 32'h4DA54F4E;
        issue(1, 0, 8'h34, 8'h00);
        n = 0;
        @(negedge CLK);
        while (!MEM_READ) begin
            n++;
            if (n > 100) begin
                $display("FAIL wait_fetch: MEM_READ still low after %0d cycles, expected high", n);
                $fatal(1);
            end
            @(negedge CLK);
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        READ  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 0;
            ref_dirty[i] = 0;
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        pin_wb_en = 0;

        // everything invalid again; the written-back byte must come back from memory
        access(1, 0, 8'h34, 8'h00, 1, 8'h6E);
        access(1, 0, 8'h16, 8'h00, 1, 8'hA5);

        // READ and WRITE together act as a store hit
        access(1, 1, 8'h15, 8'h3C, 0, 8'h00);
        access(1, 0, 8'h15, 8'h00, 1, 8'h3C);

        // request withdrawn mid-miss: the fill still completes
        issue(1, 0, 8'h08, 8'h00);
        repeat (3) @(posedge CLK);
        #1 READ = 1'b0;
        repeat (20) @(posedge CLK);
        access(1, 0, 8'h09, 8'h00, 1, 8'h53);

        // store into that line, then a conflicting read forces a full write-back
        access(0, 1, 8'h0A, 8'h77, 0, 8'h00);
        pin_wb_en  = 1;
        pin_wb_val = 32'h51775352;
        access(1, 0, 8'h2A, 8'h00, 1, 8'h70);
        pin_wb_en = 0;

        repeat (3) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
